lc3b_mem_responder: RTL and testbench

LC3B_MEM_RESPONDER -- requirements
Module: lc3b_mem_responder

---
 rtl/lc3b_mem_responder.sv | 189 ++++++++++++++++++
 tb/tb_lc3b_mem_responder.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3b_mem_responder.sv
// ---------------------------------------------------------------------------
// lc3b_mem_responder
//
// Purpose
//   Word-organised memory model with a fixed, parameterised response latency.
//   The LC-3b datapath uses it as its memory. The datapath raises mem_read or
//   mem_write and holds the request. The responder completes the request with
//   a one-cycle mem_resp pulse exactly LATENCY cycles after it accepts it.
//
// Handshake (request/complete)
//   A request is the level (mem_read | mem_write). The responder samples it
//   only while IDLE. The acceptance edge latches op, address, data and mask.
//   Any later change on the inputs is ignored until the latched transaction
//   has produced mem_resp. A request present in cycle 0 (IDLE) is answered
//   with mem_resp high in cycle LATENCY. The cycle after mem_resp is IDLE
//   again and may accept the next request with no bubble. Nothing is queued
//   while busy.
//
// Parameters
//   LATENCY    cycles from acceptance to mem_resp, 1..15
//   ADDR_BITS  log2 of the number of 16-bit words stored
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high
//   mem_read     read request (held until mem_resp)
//   mem_write    write request (held until mem_resp); wins over mem_read
//   mem_wmask    byte enables: [0] -> bits 7:0, [1] -> bits 15:8
//   mem_address  byte address; word index is mem_address[ADDR_BITS:1]
//   mem_wdata    write data
//   mem_resp     one-cycle completion pulse
//   mem_rdata    data of the most recent completed read
//   busy         transaction outstanding (BUSY or RESP)
//   dbg_state    current FSM state (IDLE=0, BUSY=1, RESP=2)
// ---------------------------------------------------------------------------
module lc3b_mem_responder #(
   parameter int LATENCY   = 3,
   parameter int ADDR_BITS = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [1:0]  mem_wmask,
   input  logic [15:0] mem_address,
   input  logic [15:0] mem_wdata,
   output logic        mem_resp,
   output logic [15:0] mem_rdata,
   output logic        busy,
   output logic [1:0]  dbg_state
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam int         WORDS    = 1 << ADDR_BITS;
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [1:0]           state_q, state_d;
   logic [3:0]           cnt_q, cnt_d;
   logic [ADDR_BITS-1:0] addr_q, addr_d;   // latched word index
   logic [15:0]          wdata_q, wdata_d;
   logic [1:0]           wmask_q, wmask_d;
   logic                 wr_q, wr_d;       // latched op: 1 = write
   logic [15:0]          rdata_q, rdata_d;

   // Storage is deliberately not reset: contents survive reset and are
   // undefined until written.
   logic [15:0]          mem [WORDS];

   logic                 req;
   logic                 mem_we;
   logic [ADDR_BITS-1:0] in_idx;

   assign req    = mem_read | mem_write;
   assign in_idx = mem_address[ADDR_BITS:1];

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wmask_d = wmask_q;
      wr_d    = wr_q;
      rdata_d = rdata_q;
      mem_we  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (req) begin
               addr_d  = in_idx;
               wdata_d = mem_wdata;
               wmask_d = mem_wmask;
               wr_d    = mem_write;
               if (LATENCY <= 1) begin
                  // Straight to RESP. The read data must come from the
                  // incoming address because the latch is loading on this
                  // same edge.
                  state_d = ST_RESP;
                  cnt_d   = 4'd0;
                  if (!mem_write) begin
                     rdata_d = mem[in_idx];
                  end
               end else begin
                  state_d = ST_BUSY;
                  cnt_d   = CNT_INIT;
               end
            end
         end

         ST_BUSY: begin
            cnt_d = cnt_q - 4'd1;
            // The <= also covers a counter that is already 0, so the FSM
            // can never stay in BUSY for good.
            if (cnt_q <= 4'd1) begin
               state_d = ST_RESP;
               if (!wr_q) begin
                  rdata_d = mem[addr_q];
               end
            end
         end

         ST_RESP: begin
            // A write commits on the edge that leaves RESP. An asynchronous
            // reset during RESP clears state_q first, so it aborts the write.
            state_d = ST_IDLE;
            mem_we  = wr_q;
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Control and data registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         wdata_q <= 16'h0000;
         wmask_q <= 2'b00;
         wr_q    <= 1'b0;
         rdata_q <= 16'h0000;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wmask_q <= wmask_d;
         wr_q    <= wr_d;
         rdata_q <= rdata_d;
      end
   end

   // ------------------------------------------------------------------------
   // Byte-masked storage write
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (mem_we) begin
         if (wmask_q[0]) begin
            mem[addr_q][7:0] <= wdata_q[7:0];
         end
         if (wmask_q[1]) begin
            mem[addr_q][15:8] <= wdata_q[15:8];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign mem_resp  = (state_q == ST_RESP);
   assign busy      = (state_q != ST_IDLE);
   assign mem_rdata = rdata_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_lc3b_mem_responder
//
// Three responders share one clock and one reset:
//   index 0 -> LATENCY 3, index 1 -> LATENCY 1, index 2 -> LATENCY 15.
// Each responder has its own request inputs.
//
// The reference model treats memory as a plain array of words, indexed by
// the byte address divided by two modulo 256. It also tracks the last
// completed read value and the latency that each instance must show.
// ---------------------------------------------------------------------------
module tb_lc3b_mem_responder;

   localparam int NI = 3;

   logic        clk;
   logic        reset;
   logic        rd_i    [NI];
   logic        wr_i    [NI];
   logic [1:0]  wm_i    [NI];
   logic [15:0] addr_i  [NI];
   logic [15:0] wd_i    [NI];
   logic        resp_o  [NI];
   logic        busy_o  [NI];
   logic [15:0] rdata_o [NI];
   logic [1:0]  st_o    [NI];

   int n_checks = 0;
   int n_fail   = 0;

   // reference model
   logic [15:0] ref_mem [NI][256];
   bit          ref_val [NI][256];
   logic [15:0] last_rd [NI];

   // ------------------------------------------------------------------------
   // Clock
   // ------------------------------------------------------------------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ------------------------------------------------------------------------
   // Devices under test
   // ------------------------------------------------------------------------
   lc3b_mem_responder #(.LATENCY(3), .ADDR_BITS(8)) u_l3 (
      .clk(clk), .reset(reset), .mem_read(rd_i[0]), .mem_write(wr_i[0]),
      .mem_wmask(wm_i[0]), .mem_address(addr_i[0]), .mem_wdata(wd_i[0]),
      .mem_resp(resp_o[0]), .mem_rdata(rdata_o[0]), .busy(busy_o[0]),
      .dbg_state(st_o[0]));

   lc3b_mem_responder #(.LATENCY(1), .ADDR_BITS(8)) u_l1 (
      .clk(clk), .reset(reset), .mem_read(rd_i[1]), .mem_write(wr_i[1]),
      .mem_wmask(wm_i[1]), .mem_address(addr_i[1]), .mem_wdata(wd_i[1]),
      .mem_resp(resp_o[1]), .mem_rdata(rdata_o[1]), .busy(busy_o[1]),
      .dbg_state(st_o[1]));

   lc3b_mem_responder #(.LATENCY(15), .ADDR_BITS(8)) u_l15 (
      .clk(clk), .reset(reset), .mem_read(rd_i[2]), .mem_write(wr_i[2]),
      .mem_wmask(wm_i[2]), .mem_address(addr_i[2]), .mem_wdata(wd_i[2]),
      .mem_resp(resp_o[2]), .mem_rdata(rdata_o[2]), .busy(busy_o[2]),
      .dbg_state(st_o[2]));

   // ------------------------------------------------------------------------
   // Helpers
   // ------------------------------------------------------------------------
   function automatic int lat_of(input int k);
      return (k == 0) ? 3 : ((k == 1) ? 1 : 15);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_req(input int k);
      rd_i[k]   = 1'b0;
      wr_i[k]   = 1'b0;
      wm_i[k]   = 2'b00;
      addr_i[k] = 16'h0000;
      wd_i[k]   = 16'h0000;
   endtask

   // Wait n cycles with no request. mem_resp and busy must stay low.
   task automatic idle(input int k, input int n);
      repeat (n) begin
         @(negedge clk);
         chk("idle_resp", 32'(resp_o[k]), 32'd0);
         chk("idle_busy", 32'(busy_o[k]), 32'd0);
      end
   endtask

   // Perform one transaction on instance k. Call at a negedge.
   //   exp_wait: 1 if the instance is idle now;
   //             2 if called at the negedge of its RESP cycle (back-to-back).
   //   scramble: randomise the inputs while the transaction is in flight.
   task automatic txn(input int k, input logic rd, input logic wr,
                      input logic [15:0] addr, input logic [15:0] wd,
                      input logic [1:0] wm, input bit scramble,
                      input int exp_wait, output logic [15:0] rd_obs);
      int lat;
      int wait_cyc;
      int cyc;
      int bc;
      int rc;
      int idx;
      logic [15:0] w;
      lat = lat_of(k);
      idx = int'(addr[8:1]);
      rd_i[k]   = rd;
      wr_i[k]   = wr;
      addr_i[k] = addr;
      wd_i[k]   = wd;
      wm_i[k]   = wm;
      wait_cyc = 0;
      do begin
         @(negedge clk);
         wait_cyc++;
      end while (!busy_o[k] && wait_cyc < 40);
      chk("accept", 32'(busy_o[k]), 32'd1);
      chk("accept_delay", 32'(wait_cyc), 32'(exp_wait));
      cyc = 1;
      bc  = 0;
      rc  = 0;
      forever begin
         if (busy_o[k]) bc++;
         if (resp_o[k]) rc++;
         if (resp_o[k] || cyc >= 40) break;
         if (scramble) begin
            rd_i[k]   = 1'($urandom);
            wr_i[k]   = 1'($urandom);
            addr_i[k] = 16'($urandom);
            wd_i[k]   = 16'($urandom);
            wm_i[k]   = 2'($urandom);
         end
         @(negedge clk);
         cyc++;
      end
      clear_req(k);
      chk("resp_seen", 32'(resp_o[k]), 32'd1);
      chk("resp_cycle", 32'(cyc), 32'(lat));
      chk("busy_cycles", 32'(bc), 32'(lat));
      chk("resp_pulses", 32'(rc), 32'd1);
      rd_obs = rdata_o[k];
      if (wr) begin
         w = ref_mem[k][idx];
         if (wm[0]) w[7:0]  = wd[7:0];
         if (wm[1]) w[15:8] = wd[15:8];
         ref_mem[k][idx] = w;
         if (wm == 2'b11) ref_val[k][idx] = 1'b1;
         chk("wr_rdata_hold", 32'(rdata_o[k]), 32'(last_rd[k]));
      end else begin
         if (ref_val[k][idx]) chk("rd_data", 32'(rdata_o[k]), 32'(ref_mem[k][idx]));
         last_rd[k] = ref_mem[k][idx];
      end
   endtask

   // ------------------------------------------------------------------------
   // Safety net
   // ------------------------------------------------------------------------
   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   initial begin
      logic [15:0] r;
      int op;
      int b2b;
      for (int k = 0; k < NI; k++) begin
         clear_req(k);
         last_rd[k] = 16'h0000;
         for (int i = 0; i < 256; i++) begin
            ref_mem[k][i] = 16'h0000;
            ref_val[k][i] = 1'b0;
         end
      end

      // reset state
      reset = 1'b1;
      repeat (3) @(negedge clk);
      for (int k = 0; k < NI; k++) begin
         chk("rst_resp", 32'(resp_o[k]), 32'd0);
         chk("rst_busy", 32'(busy_o[k]), 32'd0);
         chk("rst_rdata", 32'(rdata_o[k]), 32'h0);
         chk("rst_state", 32'(st_o[k]), 32'd0);
      end
      reset = 1'b0;

      // write then read (first request on the first edge after reset)
      txn(0, 1'b0, 1'b1, 16'h0010, 16'h1234, 2'b11, 1'b0, 1, r);
      idle(0, 1);
      txn(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, 1'b0, 1, r);
      chk("wr_rd_1234", 32'(r), 32'h1234);
      idle(0, 1);

      // byte masks
      txn(0, 1'b0, 1'b1, 16'h0020, 16'hAAAA, 2'b11, 1'b0, 1, r);
      idle(0, 1);
      txn(0, 1'b0, 1'b1, 16'h0020, 16'h5566, 2'b01, 1'b0, 1, r);
      idle(0, 1);
      txn(0, 1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, 1'b0, 1, r);
      chk("mask01", 32'(r), 32'hAA66);
      idle(0, 1);
      txn(0, 1'b0, 1'b1, 16'h0020, 16'h7799, 2'b10, 1'b0, 1, r);
      idle(0, 1);
      txn(0, 1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, 1'b0, 1, r);
      chk("mask10", 32'(r), 32'h7766);
      idle(0, 1);
      txn(0, 1'b0, 1'b1, 16'h0020, 16'hFFFF, 2'b00, 1'b0, 1, r);
      idle(0, 1);
      txn(0, 1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, 1'b0, 1, r);
      chk("mask00", 32'(r), 32'h7766);
      idle(0, 1);

      // aliasing
      txn(0, 1'b0, 1'b1, 16'h0002, 16'hBEEF, 2'b11, 1'b0, 1, r);
      idle(0, 1);
      txn(0, 1'b1, 1'b0, 16'h0202, 16'h0000, 2'b00, 1'b0, 1, r);
      chk("alias_0202", 32'(r), 32'hBEEF);
      idle(0, 1);
      txn(0, 1'b1, 1'b0, 16'h0003, 16'h0000, 2'b00, 1'b0, 1, r);
      chk("alias_0003", 32'(r), 32'hBEEF);
      idle(0, 1);

      // read+write together is a write, then back-to-back read
      txn(0, 1'b1, 1'b1, 16'h0030, 16'h4242, 2'b11, 1'b0, 1, r);
      txn(0, 1'b1, 1'b0, 16'h0030, 16'h0000, 2'b00, 1'b0, 2, r);
      chk("rdwr_b2b", 32'(r), 32'h4242);
      idle(0, 1);

      // inputs scrambled while in flight
      txn(0, 1'b0, 1'b1, 16'h0050, 16'hC0DE, 2'b11, 1'b1, 1, r);
      idle(0, 1);
      txn(0, 1'b1, 1'b0, 16'h0050, 16'h0000, 2'b00, 1'b1, 1, r);
      chk("scramble_rd", 32'(r), 32'hC0DE);
      idle(0, 1);

      // reset mid-write
      txn(0, 1'b0, 1'b1, 16'h0040, 16'h0001, 2'b11, 1'b0, 1, r);
      idle(0, 1);
      wr_i[0] = 1'b1; addr_i[0] = 16'h0040; wd_i[0] = 16'hDEAD; wm_i[0] = 2'b11;
      @(negedge clk);
      chk("midrst_busy_before", 32'(busy_o[0]), 32'd1);
      #1 reset = 1'b1;
      #1;
      chk("midrst_resp", 32'(resp_o[0]), 32'd0);
      chk("midrst_busy", 32'(busy_o[0]), 32'd0);
      chk("midrst_rdata", 32'(rdata_o[0]), 32'h0);
      clear_req(0);
      for (int k = 0; k < NI; k++) last_rd[k] = 16'h0000;
      @(negedge clk);
      chk("midrst_resp_held", 32'(resp_o[0]), 32'd0);
      reset = 1'b0;
      txn(0, 1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, 1'b0, 1, r);
      chk("midrst_old_data", 32'(r), 32'h0001);
      idle(0, 1);

      // latency sweep: LATENCY=1 and LATENCY=15
      for (int k = 1; k < NI; k++) begin
         txn(k, 1'b0, 1'b1, 16'h0010, 16'h1234, 2'b11, 1'b0, 1, r);
         idle(k, 1);
         txn(k, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, 1'b0, 1, r);
         chk("sweep_rd", 32'(r), 32'h1234);
         txn(k, 1'b0, 1'b1, 16'h0010, 16'h5678, 2'b11, 1'b0, 2, r);
         txn(k, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, 1'b0, 2, r);
         chk("sweep_b2b_rd", 32'(r), 32'h5678);
         idle(k, 2);
      end

      // randomized traffic against the model
      for (int k = 0; k < NI; k++) begin
         for (int i = 0; i < 8; i++) begin
            txn(k, 1'b0, 1'b1, {7'($urandom), 8'(i), 1'($urandom)},
                16'($urandom), 2'b11, 1'b0, 1, r);
            idle(k, 1);
         end
         for (int n = 0; n < 25; n++) begin
            op  = $urandom_range(0, 2);
            b2b = $urandom_range(0, 1);
            if (b2b == 0) idle(k, $urandom_range(1, 3));
            txn(k, (op != 1), (op != 0),
                {7'($urandom), 8'($urandom_range(0, 7)), 1'($urandom)},
                16'($urandom), 2'($urandom), 1'($urandom),
                (b2b == 0) ? 1 : 2, r);
         end
         idle(k, 2);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
